bp_be_pair_issue_scheduler: RTL and testbench
=============================================

# bp_be_pair_issue_scheduler

In-order dual-issue scheduler between the BE instruction-pair queue and the dual-issue scoreboard (`bp_be_scoreboard_di`). It buffers one instruction pair and queries the scoreboard for RAW/WAW hazards on both slots. It then issues both slots together, slot 0 alone, or nothing. It also drives the scoreboard score ports for every issued register-writing instruction. Slot 1 never issues ahead of slot 0.

## Interface
- `bp_params_p`, default `e_bp_default_cfg`: processor config; supplies `reg_addr_width_gp`.
- `num_rs_p`, default 2: source operands per instruction.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `flush_i`  in  1  drop buffered pair; suppress issue and score this cycle.
- `pair_v_i`  in  1  pair valid.
- `pair_ready_and_o`  out  1  pair accepted when `pair_v_i & pair_ready_and_o`.
- `instr0_v_i`, `instr1_v_i`  in  1 each  slot occupied.
- `instr0_rs_i`, `instr1_rs_i`  in  num_rs_p x reg_addr_width_gp  source regs.
- `instr0_rd_i`, `instr1_rd_i`  in  reg_addr_width_gp  destination.
- `instr0_rd_w_v_i`, `instr1_rd_w_v_i`  in  1  writes rd.
- `sb_rs0_o`, `sb_rs1_o`  out  num_rs_p x reg_addr_width_gp  to scoreboard `rs_i1`/`rs_i2`.
- `sb_rd0_o`, `sb_rd1_o`  out  reg_addr_width_gp  to scoreboard `rd_i`/`rd_i2`.
- `sb_rs_match0_i`, `sb_rs_match1_i`  in  num_rs_p  from scoreboard.
- `sb_rd_match0_i`, `sb_rd_match1_i`  in  1  from scoreboard.
- `score_v0_o`, `score_v1_o`  out  1  score enable.
- `score_rd0_o`, `score_rd1_o`  out  reg_addr_width_gp  score address.
- `dispatch_ready_i`  in  1  execution pipe accepts issue.
- `dispatch0_v_o`, `dispatch1_v_o`  out  1  slot issued this cycle.
- `stall_cnt_o`  out  8  saturating hazard-stall cycle counter.

## Operation
- States:
  - `e_empty`: nothing held.
  - `e_pair`: both or only slot 0 pending.
  - `e_second`: only slot 1 pending.
- Accept: the pair is registered. Next state is `e_pair` if `instr0_v_i`, else `e_second` if `instr1_v_i`, else stay `e_empty`.
- Scoreboard drive, `e_pair`:
  - Port 1 carries instr0 and port 2 carries instr1.
  - `sb_rd0_o` = `instr0_rd_w_v ? rd0 : 0`. This makes the scoreboard's intra-pair `rs2==rd_i` compare hit only on a real producer.
- Scoreboard drive, `e_second`: instr1 is driven on port 1; port 2 is driven to 0 and its matches are ignored.
- Hazard for a slot:
  - Any `rs_match[i]` with `rs[i] != 0`, or
  - `rd_match` with `rd_w_v & rd != 0`.
  - x0 never hazards and is never scored.
- Issue, `e_pair`:
  - `dispatch0_v_o` = `dispatch_ready_i & ~flush_i & ~haz0`.
  - `dispatch1_v_o` = `dispatch0_v_o & instr1_v & ~haz1`.
- Issue, `e_second`: `dispatch1_v_o` = `dispatch_ready_i & ~flush_i & ~haz(port 1)`.
- Transitions:
  - `e_pair` to `e_empty` when slot 0 issues and slot 1 is absent or issues.
  - `e_pair` to `e_second` when slot 0 issues and slot 1 is held.
  - `e_second` to `e_empty` on issue.
  - `flush_i` forces `e_empty` from any state.
- Score: `score_vN_o` = `dispatchN_v_o & rd_w_v & rd != 0`, with `score_rdN_o` = that rd.
- Ready: `pair_ready_and_o` = `~flush_i & (e_empty | last pending slot issues this cycle)`. Back-to-back pairs then run with no bubble.
- Stall counter:
  - Increments on any cycle with a pending slot, `dispatch_ready_i` high, and no issue caused by a hazard.
  - Saturates at 255.

## Timing
- Pair accepted at edge N can issue in cycle N+1 at earliest.
- Dispatch and score are combinational from state plus scoreboard matches in the same cycle. The scoreboard bit is set at the following edge.
- `dispatch_ready_i` low: no issue, no score, state held, counter frozen.
- `flush_i` together with `pair_v_i`: the pair is not accepted (ready is low).
- A scoreboard clear in the same cycle is visible only the next cycle; the scheduler waits one cycle.
- Reset mid-operation: state goes to `e_empty` and the buffer is invalidated. All dispatch/score outputs are 0, `pair_ready_and_o` is 1, and `stall_cnt_o` is 0 in the cycle after reset deasserts.

## Structure
- The state enum `bp_be_pair_issue_state_e` goes in `bp_be_pkg`.
- The hazard-mask function (x0 masking, rd-write qualification) is a sub-module, `bp_be_issue_hazard`, instantiated twice.
- The register buffer uses `bsg_dff_reset_en`.

## Test plan
- Independent pair: rs0={1,2}, rd0=3; rs1={4,5}, rd1=6; empty scoreboard -> both dispatch next cycle; score 3 and 6; back-to-back pair accepted same cycle.
- Intra-pair RAW: rd0=7, rs1[0]=7 -> slot 0 issues and scores 7; state `e_second`; slot 1 issues after writeback clears 7.
- x0 cases:
  - instr0 writes x0 and instr1 reads x0 -> both issue, no score.
  - instr0 has `rd_w_v=0` with rd=9, and rs1=9 -> both issue.
- Scoreboard busy: reg 5 scored, rs0[1]=5 -> nothing issues, `stall_cnt_o` increments per cycle, saturates at 255 after 300 stall cycles.
- `dispatch_ready_i` low for 3 cycles with a clean pair -> no issue and counter stays 0; issue on the 4th cycle.
- Flush in `e_second`, and reset asserted mid-stall -> `e_empty`, no dispatch or score that cycle, ready high next cycle, counter 0 after reset.

Source files
------------

// File: rtl/bp_be_pkg.sv
// Shared types for the BE pair-issue path: processor config selector,
// register-address width lookup and the pair scheduler state encoding.
package bp_be_pkg;

    typedef enum logic [3:0] {
        e_bp_default_cfg = 4'd0
    } bp_params_e;

    typedef enum logic [1:0] {
        e_empty  = 2'd0,
        e_pair   = 2'd1,
        e_second = 2'd2
    } bp_be_pair_issue_state_e;

    localparam int stall_cnt_width_gp = 8;

    function automatic int bp_reg_addr_width(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return 5;
            default:          return 5;
        endcase
    endfunction

endpackage

// File: rtl/bp_be_issue_hazard.sv
// Turns raw scoreboard match bits into a single hazard flag for one issue
// slot; x0 sources never hazard and a destination only counts if written.
module bp_be_issue_hazard
    #(parameter int num_rs_p = 2
    , parameter int addr_width_p = 5
    )
    (input  logic [num_rs_p-1:0][addr_width_p-1:0] rs_i
    , input  logic [addr_width_p-1:0]              rd_i
    , input  logic                                 rd_w_v_i
    , input  logic [num_rs_p-1:0]                  rs_match_i
    , input  logic                                 rd_match_i
    , output logic                                 haz_o
    );

    always_comb begin
        haz_o = rd_match_i & rd_w_v_i & (rd_i != '0);
        for (int i = 0; i < num_rs_p; i++) begin
            if (rs_match_i[i] && (rs_i[i] != '0)) begin
                haz_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsg_dff_reset_en.sv
// Enabled register with synchronous active-high reset to a constant.
module bsg_dff_reset_en
    #(parameter int width_p = 1
    , parameter logic [width_p-1:0] reset_val_p = '0
    )
    (input  logic               clk_i
    , input  logic               reset_i
    , input  logic               en_i
    , input  logic [width_p-1:0] data_i
    , output logic [width_p-1:0] data_o
    );

    logic [width_p-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= reset_val_p;
        end else if (en_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bp_be_pair_issue_scheduler.sv
// In-order dual-issue scheduler: holds one instruction pair, checks both slots
// against the dual-issue scoreboard and issues pair, slot 0 alone, or nothing.
module bp_be_pair_issue_scheduler
    import bp_be_pkg::*;
    #(parameter bp_params_e bp_params_p = e_bp_default_cfg
    , parameter int num_rs_p = 2
    , localparam int reg_addr_width_lp = bp_reg_addr_width(bp_params_p)
    )
    (input  logic                                           clk_i
    , input  logic                                           reset_i
    , input  logic                                           flush_i
    , input  logic                                           pair_v_i
    , output logic                                           pair_ready_and_o
    , input  logic                                           instr0_v_i
    , input  logic                                           instr1_v_i
    , input  logic [num_rs_p-1:0][reg_addr_width_lp-1:0]     instr0_rs_i
    , input  logic [num_rs_p-1:0][reg_addr_width_lp-1:0]     instr1_rs_i
    , input  logic [reg_addr_width_lp-1:0]                   instr0_rd_i
    , input  logic [reg_addr_width_lp-1:0]                   instr1_rd_i
    , input  logic                                           instr0_rd_w_v_i
    , input  logic                                           instr1_rd_w_v_i
    , output logic [num_rs_p-1:0][reg_addr_width_lp-1:0]     sb_rs0_o
    , output logic [num_rs_p-1:0][reg_addr_width_lp-1:0]     sb_rs1_o
    , output logic [reg_addr_width_lp-1:0]                   sb_rd0_o
    , output logic [reg_addr_width_lp-1:0]                   sb_rd1_o
    , input  logic [num_rs_p-1:0]                            sb_rs_match0_i
    , input  logic [num_rs_p-1:0]                            sb_rs_match1_i
    , input  logic                                           sb_rd_match0_i
    , input  logic                                           sb_rd_match1_i
    , output logic                                           score_v0_o
    , output logic                                           score_v1_o
    , output logic [reg_addr_width_lp-1:0]                   score_rd0_o
    , output logic [reg_addr_width_lp-1:0]                   score_rd1_o
    , input  logic                                           dispatch_ready_i
    , output logic                                           dispatch0_v_o
    , output logic                                           dispatch1_v_o
    , output logic [stall_cnt_width_gp-1:0]                  stall_cnt_o
    );

    localparam int instr_w_lp = num_rs_p*reg_addr_width_lp + reg_addr_width_lp + 1;
    localparam int buf_w_lp   = 1 + 2*instr_w_lp;

    function automatic logic [stall_cnt_width_gp-1:0] sat_inc(input logic [stall_cnt_width_gp-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    bp_be_pair_issue_state_e state_q, state_d;
    logic [stall_cnt_width_gp-1:0] cnt_q, cnt_d;

    logic [buf_w_lp-1:0] buf_d, buf_q;
    logic                                       v1_q, w0_q, w1_q;
    logic [num_rs_p-1:0][reg_addr_width_lp-1:0] rs0_q, rs1_q;
    logic [reg_addr_width_lp-1:0]               rd0_q, rd1_q;

    logic accept, issue_ok, last_issue, stall, p1_w_v;
    logic haz0, haz1;

    assign buf_d = {instr1_v_i, instr0_rs_i, instr0_rd_i, instr0_rd_w_v_i,
                    instr1_rs_i, instr1_rd_i, instr1_rd_w_v_i};

    bsg_dff_reset_en #(.width_p(buf_w_lp)) pair_buf
        (.clk_i  (clk_i)
        ,.reset_i(reset_i)
        ,.en_i   (accept)
        ,.data_i (buf_d)
        ,.data_o (buf_q)
        );

    assign {v1_q, rs0_q, rd0_q, w0_q, rs1_q, rd1_q, w1_q} = buf_q;

    // Port 1 always carries the oldest pending instruction; port 2 only the younger slot of a full pair.
    always_comb begin
        sb_rs0_o = '0;
        sb_rd0_o = '0;
        sb_rs1_o = '0;
        sb_rd1_o = '0;
        p1_w_v   = 1'b0;
        case (state_q)
            e_pair: begin
                sb_rs0_o = rs0_q;
                sb_rd0_o = w0_q ? rd0_q : '0;
                sb_rs1_o = rs1_q;
                sb_rd1_o = rd1_q;
                p1_w_v   = w0_q;
            end
            e_second: begin
                sb_rs0_o = rs1_q;
                sb_rd0_o = w1_q ? rd1_q : '0;
                p1_w_v   = w1_q;
            end
            default: ;
        endcase
    end

    bp_be_issue_hazard #(.num_rs_p(num_rs_p), .addr_width_p(reg_addr_width_lp)) hazard_p1
        (.rs_i      (sb_rs0_o)
        ,.rd_i      (sb_rd0_o)
        ,.rd_w_v_i  (p1_w_v)
        ,.rs_match_i(sb_rs_match0_i)
        ,.rd_match_i(sb_rd_match0_i)
        ,.haz_o     (haz0)
        );

    bp_be_issue_hazard #(.num_rs_p(num_rs_p), .addr_width_p(reg_addr_width_lp)) hazard_p2
        (.rs_i      (sb_rs1_o)
        ,.rd_i      (sb_rd1_o)
        ,.rd_w_v_i  (w1_q)
        ,.rs_match_i(sb_rs_match1_i)
        ,.rd_match_i(sb_rd_match1_i)
        ,.haz_o     (haz1)
        );

    assign issue_ok      = dispatch_ready_i & ~flush_i;
    assign dispatch0_v_o = (state_q == e_pair) & issue_ok & ~haz0;
    assign dispatch1_v_o = (state_q == e_pair)   ? (dispatch0_v_o & v1_q & ~haz1)
                         : (state_q == e_second) & issue_ok & ~haz0;

    assign last_issue = (state_q == e_pair)   ? (dispatch0_v_o & (~v1_q | dispatch1_v_o))
                      : (state_q == e_second) & dispatch1_v_o;

    // Refilling on the same edge the last slot leaves keeps back-to-back pairs bubble-free.
    assign pair_ready_and_o = ~flush_i & ((state_q == e_empty) | last_issue);
    assign accept           = pair_v_i & pair_ready_and_o;

    assign score_v0_o  = dispatch0_v_o & w0_q & (rd0_q != '0);
    assign score_rd0_o = rd0_q;
    assign score_v1_o  = dispatch1_v_o & w1_q & (rd1_q != '0);
    assign score_rd1_o = rd1_q;

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = e_empty;
        end else begin
            if (state_q == e_pair && dispatch0_v_o) begin
                state_d = last_issue ? e_empty : e_second;
            end else if (state_q == e_second && dispatch1_v_o) begin
                state_d = e_empty;
            end
            if (accept) begin
                state_d = instr0_v_i ? e_pair : (instr1_v_i ? e_second : e_empty);
            end
        end
    end

    // The oldest pending slot is always on port 1, so its hazard alone decides a stall.
    assign stall = issue_ok & (state_q != e_empty) & haz0;
    assign cnt_d = stall ? sat_inc(cnt_q) : cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_empty;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_bp_be_pair_issue_scheduler.sv
// Random and directed stimulus against a queue-based model of in-order pair issue.
module tb_bp_be_pair_issue_scheduler;

    typedef struct packed {
        logic [1:0][4:0] rs;
        logic [4:0]      rd;
        logic            wv;
        logic            slot;
    } ins_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, flush, pv, v0, v1, dready;
    ins_t            i0, i1;
    logic [31:0]     clr;
    logic            ready, d0, d1, sv0, sv1;
    logic [1:0][4:0] sb_rs0, sb_rs1;
    logic [4:0]      sb_rd0, sb_rd1, srd0, srd1;
    logic [1:0]      m_rs0, m_rs1;
    logic            m_rd0, m_rd1;
    logic [7:0]      cnt;

    // Scoreboard stand-in and reference state
    logic [31:0] busy, busy_n;
    ins_t        pend[$], pend_n[$];
    int          cnt_m, cnt_n;
    int          n_vec = 0, n_err = 0;

    bp_be_pair_issue_scheduler dut
        (.clk_i(clk), .reset_i(rst), .flush_i(flush)
        ,.pair_v_i(pv), .pair_ready_and_o(ready)
        ,.instr0_v_i(v0), .instr1_v_i(v1)
        ,.instr0_rs_i(i0.rs), .instr1_rs_i(i1.rs)
        ,.instr0_rd_i(i0.rd), .instr1_rd_i(i1.rd)
        ,.instr0_rd_w_v_i(i0.wv), .instr1_rd_w_v_i(i1.wv)
        ,.sb_rs0_o(sb_rs0), .sb_rs1_o(sb_rs1), .sb_rd0_o(sb_rd0), .sb_rd1_o(sb_rd1)
        ,.sb_rs_match0_i(m_rs0), .sb_rs_match1_i(m_rs1)
        ,.sb_rd_match0_i(m_rd0), .sb_rd_match1_i(m_rd1)
        ,.score_v0_o(sv0), .score_v1_o(sv1), .score_rd0_o(srd0), .score_rd1_o(srd1)
        ,.dispatch_ready_i(dready), .dispatch0_v_o(d0), .dispatch1_v_o(d1)
        ,.stall_cnt_o(cnt)
        );

    // Dual-issue scoreboard: port 2 also sees port 1's destination (intra-pair RAW/WAW)
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            m_rs0[i] = busy[sb_rs0[i]];
            m_rs1[i] = busy[sb_rs1[i]] | (sb_rs1[i] == sb_rd0);
        end
        m_rd0 = busy[sb_rd0];
        m_rd1 = busy[sb_rd1] | (sb_rd1 == sb_rd0);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit haz(input ins_t x, input logic [31:0] b, input logic [4:0] prod);
        bit h = 1'b0;
        for (int i = 0; i < 2; i++)
            if (x.rs[i] != 5'd0 && (b[x.rs[i]] || x.rs[i] == prod)) h = 1'b1;
        if (x.wv && x.rd != 5'd0 && (b[x.rd] || x.rd == prod)) h = 1'b1;
        return h;
    endfunction

    task automatic tick();
        int   niss = 0;
        bit   stall = 1'b0, rdy = 1'b0;
        bit   d0e = 1'b0, d1e = 1'b0, s0e = 1'b0, s1e = 1'b0;
        logic [4:0]  r0e = '0, r1e = '0, prod;
        logic [31:0] setm = '0;
        ins_t x;
        #1;
        if (!rst) begin
            if (pend.size() > 0) begin
                if (dready && !flush) begin
                    if (!haz(pend[0], busy, 5'd0)) niss = 1;
                    else stall = 1'b1;
                end
                if (niss == 1 && pend.size() == 2) begin
                    prod = pend[0].wv ? pend[0].rd : 5'd0;
                    if (!haz(pend[1], busy, prod)) niss = 2;
                end
            end
            rdy = !flush && (niss == pend.size());
            for (int k = 0; k < niss; k++) begin
                x = pend[k];
                if (x.wv && x.rd != 5'd0) setm[x.rd] = 1'b1;
                if (x.slot) begin d1e = 1'b1; s1e = x.wv && x.rd != 0; r1e = x.rd; end
                else        begin d0e = 1'b1; s0e = x.wv && x.rd != 0; r0e = x.rd; end
            end
            check_val("dispatch", 32'({d0, d1}), 32'({d0e, d1e}));
            check_val("score_v", 32'({sv0, sv1}), 32'({s0e, s1e}));
            if (s0e) check_val("score_rd0", 32'(srd0), 32'(r0e));
            if (s1e) check_val("score_rd1", 32'(srd1), 32'(r1e));
            check_val("ready", 32'(ready), 32'(rdy));
            check_val("stall_cnt", 32'(cnt), 32'(cnt_m));
        end
        if (rst) begin
            pend_n = {};
            cnt_n  = 0;
            busy_n = '0;
        end else begin
            pend_n = pend;
            for (int k = 0; k < niss; k++) void'(pend_n.pop_front());
            if (flush) pend_n = {};
            if (pv && rdy) begin
                x = i0; x.slot = 1'b0; if (v0) pend_n.push_back(x);
                x = i1; x.slot = 1'b1; if (v1) pend_n.push_back(x);
            end
            cnt_n  = stall ? ((cnt_m == 255) ? 255 : cnt_m + 1) : cnt_m;
            busy_n = ((busy & ~clr) | setm) & 32'hFFFF_FFFE;
        end
        @(negedge clk);
        pend  = pend_n;
        busy  = busy_n;
        cnt_m = cnt_n;
    endtask

    task automatic set_pair(input bit a_v, input logic [4:0] a0, input logic [4:0] a1,
                            input logic [4:0] ard, input bit aw,
                            input bit b_v, input logic [4:0] b0, input logic [4:0] b1,
                            input logic [4:0] brd, input bit bw);
        pv = 1'b1; v0 = a_v; v1 = b_v;
        i0.rs[0] = a0; i0.rs[1] = a1; i0.rd = ard; i0.wv = aw; i0.slot = 1'b0;
        i1.rs[0] = b0; i1.rs[1] = b1; i1.rd = brd; i1.wv = bw; i1.slot = 1'b1;
    endtask

    task automatic clear_all();
        pv = 1'b0; clr = '1; tick(); clr = '0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; pv = 1'b0; v0 = 1'b0; v1 = 1'b0; dready = 1'b1;
        i0 = '0; i1 = '0; clr = '0; busy = '0; cnt_m = 0;
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;
        tick();
        check_val("rst_ready", 32'(ready), 32'd1);

        // Independent pair then back-to-back pair
        set_pair(1, 1, 2, 3, 1, 1, 4, 5, 6, 1); tick();
        set_pair(1, 8, 9, 10, 1, 1, 11, 12, 13, 1); tick();
        pv = 1'b0; tick();
        clear_all();

        // Intra-pair RAW on x7; writeback clear lands one cycle before slot 1 can go
        set_pair(1, 1, 2, 7, 1, 1, 7, 0, 8, 1); tick();
        pv = 1'b0; tick(); tick();
        clr = 32'h80; tick(); clr = '0;
        tick(); tick();
        clear_all();

        // x0 producer/consumer, and a non-writing rd=9
        set_pair(1, 1, 2, 0, 1, 1, 0, 0, 0, 1); tick();
        set_pair(1, 1, 2, 9, 0, 1, 9, 1, 4, 1); tick();
        pv = 1'b0; tick();
        clear_all();

        // Flush while only slot 1 is pending
        set_pair(1, 1, 2, 7, 1, 1, 7, 0, 8, 1); tick();
        pv = 1'b0; tick();
        flush = 1'b1; tick(); flush = 1'b0;
        tick();
        clear_all();

        // Busy x5 stalls the next pair long enough to saturate, then reset mid-stall
        set_pair(1, 1, 2, 5, 1, 0, 0, 0, 0, 0); tick();
        set_pair(1, 1, 5, 2, 1, 1, 3, 4, 6, 1); tick();
        pv = 1'b0;
        repeat (300) tick();
        check_val("stall_sat", 32'(cnt), 32'd255);
        rst = 1'b1; tick(); rst = 1'b0;
        tick();
        check_val("rst_cnt", 32'(cnt), 32'd0);

        // Execution pipe holds off three cycles
        set_pair(1, 1, 2, 3, 1, 1, 4, 5, 6, 1); tick();
        pv = 1'b0; dready = 1'b0;
        repeat (3) tick();
        dready = 1'b1; tick();
        check_val("dready_cnt", 32'(cnt), 32'd0);
        clear_all();

        // Randomized traffic over a small register range to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            pv = ($urandom_range(0, 99) < 60);
            v0 = ($urandom_range(0, 99) < 85);
            v1 = ($urandom_range(0, 99) < 75);
            for (int i = 0; i < 2; i++) begin
                i0.rs[i] = 5'($urandom_range(0, 7));
                i1.rs[i] = 5'($urandom_range(0, 7));
            end
            i0.rd = 5'($urandom_range(0, 7)); i0.wv = $urandom_range(0, 3) != 0;
            i1.rd = 5'($urandom_range(0, 7)); i1.wv = $urandom_range(0, 3) != 0;
            dready = ($urandom_range(0, 99) < 75);
            flush  = ($urandom_range(0, 99) < 4);
            rst    = ($urandom_range(0, 999) < 8);
            clr    = busy & $urandom() & $urandom();
            tick();
        end
        rst = 1'b0; flush = 1'b0; pv = 1'b0; clr = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
